// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP transmit arbiter.
//   WORD_W              - serializer word width
//   DEFAULT_NREQ        - default requester count
//   DEFAULT_STALL_LIMIT - default watchdog limit in cycles
//   STALL_CNT_W         - watchdog counter width (holds limits up to 255)
//   arb_state_t         - arbiter FSM state encoding
package ssp_pkg;

   localparam int unsigned WORD_W              = 8;
   localparam int unsigned DEFAULT_NREQ        = 4;
   localparam int unsigned DEFAULT_STALL_LIMIT = 255;
   localparam int unsigned STALL_CNT_W         = 8;

   typedef enum logic [0:0] {
      ARB_IDLE,
      ARB_OWN
   } arb_state_t;

endpackage

// File: rtl/ssp_rr_pick.sv
// Combinational round-robin picker.
//   REQ  - request vector
//   ptr  - index of the previous winner; scanning starts at ptr+1
//   pick - one-hot winner (zero when nothing requests)
//   any  - at least one request present
module ssp_rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] REQ,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic            any
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         idx = PW'((int'(ptr) + k) % int'(NREQ));
         if (!found && REQ[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      any = |REQ;
   end

endmodule

// File: rtl/ssp_tx_arbiter.sv
// Round-robin arbiter sharing the SSP serializer transmit interface between
// NREQ requesters, one whole message (ended by LAST) per grant, with a
// one-word buffer toward the serializer and a stall watchdog.
//   PCLK, CLEAR          - clock, asynchronous active-high reset
//   REQ/REQ_DATA/REQ_LAST - per-requester word offer, lane i at [8i+7:8i]
//   REQ_ACK              - combinational accept strobe to the owner
//   GRANT                - registered one-hot owner, zero when idle
//   TxData/TxValidWord/TxIsEmpty - buffered word toward the serializer
//   TxNextWord           - serializer consumed TxData this cycle
//   ABORT                - one-cycle pulse after the watchdog reclaims a grant
module ssp_tx_arbiter
   import ssp_pkg::*;
#(
   parameter int unsigned NREQ        = DEFAULT_NREQ,
   parameter int unsigned STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
   input  logic                   PCLK,
   input  logic                   CLEAR,
   input  logic [NREQ-1:0]        REQ,
   input  logic [WORD_W*NREQ-1:0] REQ_DATA,
   input  logic [NREQ-1:0]        REQ_LAST,
   output logic [NREQ-1:0]        REQ_ACK,
   output logic [NREQ-1:0]        GRANT,
   output logic [WORD_W-1:0]      TxData,
   output logic                   TxValidWord,
   output logic                   TxIsEmpty,
   input  logic                   TxNextWord,
   output logic                   ABORT
);

   localparam int unsigned PW = $clog2(NREQ);

   arb_state_t             state_q, state_d;
   logic [NREQ-1:0]        grant_q, grant_d, pick;
   logic [PW-1:0]          ptr_q, ptr_d, owner;
   logic                   valid_q, valid_d;
   logic [WORD_W-1:0]      data_q, data_d, lane_data;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic                   abort_q, abort_d;
   logic                   pick_any, own_req, lane_last, fill;

   ssp_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .REQ  (REQ),
      .ptr  (ptr_q),
      .pick (pick),
      .any  (pick_any)
   );

   // Owner lane mux driven only by the registered grant, so ACK never
   // depends on REQ_DATA.
   always_comb begin
      owner     = '0;
      lane_data = '0;
      lane_last = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_q[i]) begin
            owner     = PW'(i);
            lane_data = REQ_DATA[WORD_W*i +: WORD_W];
            lane_last = REQ_LAST[i];
         end
      end
      own_req = |(REQ & grant_q);
      fill    = (state_q == ARB_OWN) && own_req && (!valid_q || TxNextWord) && !CLEAR;
   end

   assign REQ_ACK     = fill ? grant_q : '0;
   assign GRANT       = grant_q;
   assign TxData      = data_q;
   assign TxValidWord = valid_q;
   assign TxIsEmpty   = ~valid_q;
   assign ABORT       = abort_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      abort_d = 1'b0;

      // Buffer: a fill wins over a drain, so drain+fill keeps it valid.
      if (fill) begin
         valid_d = 1'b1;
         data_d  = lane_data;
      end else if (TxNextWord) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         ARB_IDLE: begin
            cnt_d = '0;
            if (pick_any) begin
               grant_d = pick;
               state_d = ARB_OWN;
            end
         end
         ARB_OWN: begin
            if (own_req) begin
               // A requesting owner is never stalled, even when back-pressured.
               cnt_d = '0;
               if (fill && lane_last) begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
                  ptr_d   = owner;
               end
            end else if (cnt_q == STALL_CNT_W'(STALL_LIMIT - 1)) begin
               abort_d = 1'b1;
               state_d = ARB_IDLE;
               grant_d = '0;
               ptr_d   = owner;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge CLEAR) begin
      if (CLEAR) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= PW'(NREQ - 1);
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

endmodule

// File: tb/tb_ssp_tx_arbiter.sv
// Self-checking bench for ssp_tx_arbiter: requester lane model, serializer
// drain control and a scoreboard of expected delivered words.
module tb_ssp_tx_arbiter;

   localparam int unsigned NREQ        = 4;
   localparam int unsigned STALL_LIMIT = 4;

   logic              PCLK = 1'b0;
   logic              CLEAR;
   logic [NREQ-1:0]   REQ, REQ_LAST, REQ_ACK, GRANT;
   logic [8*NREQ-1:0] REQ_DATA;
   logic [7:0]        TxData;
   logic              TxValidWord, TxIsEmpty, TxNextWord, ABORT;

   ssp_tx_arbiter #(
      .NREQ        (NREQ),
      .STALL_LIMIT (STALL_LIMIT)
   ) dut (
      .PCLK        (PCLK),
      .CLEAR       (CLEAR),
      .REQ         (REQ),
      .REQ_DATA    (REQ_DATA),
      .REQ_LAST    (REQ_LAST),
      .REQ_ACK     (REQ_ACK),
      .GRANT       (GRANT),
      .TxData      (TxData),
      .TxValidWord (TxValidWord),
      .TxIsEmpty   (TxIsEmpty),
      .TxNextWord  (TxNextWord),
      .ABORT       (ABORT)
   );

   always #5 PCLK = ~PCLK;

   int              checks = 0;
   int              errors = 0;
   logic [8:0]      lane_mem [NREQ][16];  // {last, data}
   int              lane_len [NREQ];
   int              lane_pos [NREQ];
   logic [NREQ-1:0] lane_en;
   logic [NREQ-1:0] acks_s;
   logic            nw;
   logic [7:0]      sb [$];

   typedef struct packed {
      logic [NREQ-1:0] load;
      logic [NREQ-1:0] grant;
   } rr_vec_t;
   rr_vec_t rr_tab [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic load(input int ln, input logic [7:0] d, input logic last, input bit to_sb);
      lane_mem[ln][lane_len[ln]] = {last, d};
      lane_len[ln]++;
      if (to_sb) sb.push_back(d);
   endtask

   task automatic drive();
      for (int i = 0; i < int'(NREQ); i++) begin
         if (lane_en[i] && lane_pos[i] < lane_len[i]) begin
            REQ[i]           = 1'b1;
            REQ_DATA[8*i +: 8] = lane_mem[i][lane_pos[i]][7:0];
            REQ_LAST[i]      = lane_mem[i][lane_pos[i]][8];
         end else begin
            // Idle lanes offer junk with LAST set; it must be ignored.
            REQ[i]           = 1'b0;
            REQ_DATA[8*i +: 8] = 8'hEE;
            REQ_LAST[i]      = 1'b1;
         end
      end
      TxNextWord = nw;
   endtask

   // Advance one clock: requesters step on the ACK seen last cycle, new
   // inputs are applied, outputs are observed on the falling edge.
   task automatic cycle();
      @(posedge PCLK);
      #1;
      for (int i = 0; i < int'(NREQ); i++) if (acks_s[i]) lane_pos[i]++;
      drive();
      @(negedge PCLK);
      acks_s = REQ_ACK;
      if (TxValidWord && TxNextWord) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got word %0h, required none", TxData);
         end else begin
            check("sb_data", 32'(TxData), 32'(sb.pop_front()));
         end
      end
   endtask

   task automatic wait_grant(input bit want, input string name);
      int n = 0;
      while (((GRANT != '0) != want) && n < 30) begin
         cycle();
         n++;
      end
      if ((GRANT != '0) != want) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, got GRANT=%b, required nonzero=%0d", name, GRANT, want);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < int'(NREQ); i++) begin
         lane_len[i] = 0;
         lane_pos[i] = 0;
      end
      acks_s = '0;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      int acks, aborts, invalid;

      rr_tab[0] = '{load: 4'b1111, grant: 4'b0001};
      rr_tab[1] = '{load: 4'b0000, grant: 4'b0010};
      rr_tab[2] = '{load: 4'b0001, grant: 4'b0100};
      rr_tab[3] = '{load: 4'b0000, grant: 4'b1000};
      rr_tab[4] = '{load: 4'b0010, grant: 4'b0001};
      rr_tab[5] = '{load: 4'b1000, grant: 4'b0010};
      rr_tab[6] = '{load: 4'b0000, grant: 4'b1000};

      CLEAR   = 1'b1;
      lane_en = '1;
      nw      = 1'b1;
      reset_model();
      drive();
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_grant", 32'(GRANT), 32'(0));
      check("rst_valid", 32'(TxValidWord), 32'(0));
      check("rst_empty", 32'(TxIsEmpty), 32'(1));
      check("rst_abort", 32'(ABORT), 32'(0));
      check("rst_ack", 32'(REQ_ACK), 32'(0));
      check("rst_data", 32'(TxData), 32'(0));
      CLEAR = 1'b0;

      // Round-robin: one-word LAST messages, expected owner per step.
      for (int s = 0; s < 7; s++) begin
         for (int i = 0; i < int'(NREQ); i++)
            if (rr_tab[s].load[i]) load(i, 8'(16*s + i), 1'b1, 1'b0);
         wait_grant(1'b1, "rr_wait");
         check($sformatf("rr_grant_%0d", s), 32'(GRANT), 32'(rr_tab[s].grant));
         for (int i = 0; i < int'(NREQ); i++)
            if (rr_tab[s].grant[i]) sb.push_back(lane_mem[i][lane_pos[i]][7:0]);
         wait_grant(1'b0, "rr_release");
      end

      // Single two-word message from requester 1, drain every other cycle.
      load(1, 8'hA5, 1'b0, 1'b1);
      load(1, 8'h3C, 1'b1, 1'b1);
      acks = 0;
      for (int k = 0; k < 14; k++) begin
         nw = k[0];
         cycle();
         if (REQ_ACK[1]) acks++;
         if (k == 0) check("sm_grant_c0", 32'(GRANT), 32'(0));
         if (k == 1) begin
            check("sm_grant_c1", 32'(GRANT), 32'(4'b0010));
            check("sm_ack_c1", 32'(REQ_ACK), 32'(4'b0010));
         end
         if (k == 2) check("sm_valid_c2", 32'(TxValidWord), 32'(1));
      end
      check("sm_ack_count", 32'(acks), 32'(2));
      check("sm_grant_end", 32'(GRANT), 32'(0));
      check("sm_delivered", 32'(sb.size()), 32'(0));

      // Back-pressure on requester 2, then drain and refill in one cycle.
      nw = 1'b0;
      load(2, 8'h71, 1'b0, 1'b1);
      load(2, 8'h72, 1'b1, 1'b1);
      wait_grant(1'b1, "bp_wait");
      check("bp_grant", 32'(GRANT), 32'(4'b0100));
      acks = REQ_ACK[2] ? 1 : 0;
      aborts = 0;
      invalid = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (REQ_ACK[2]) acks++;
         if (ABORT) aborts++;
         if (!TxValidWord) invalid++;
      end
      check("bp_ack_count", 32'(acks), 32'(1));
      check("bp_abort_count", 32'(aborts), 32'(0));
      check("bp_invalid_cycles", 32'(invalid), 32'(0));
      check("bp_grant_held", 32'(GRANT), 32'(4'b0100));
      nw = 1'b1;
      cycle();
      check("df_ack", 32'(REQ_ACK), 32'(4'b0100));
      check("df_empty_a", 32'(TxIsEmpty), 32'(0));
      cycle();
      check("df_data", 32'(TxData), 32'(8'h72));
      check("df_empty_b", 32'(TxIsEmpty), 32'(0));
      check("df_grant_end", 32'(GRANT), 32'(0));

      // Stall watchdog: requester 3 stops after one word, requester 0 waits.
      nw = 1'b0;
      load(3, 8'h51, 1'b0, 1'b1);
      load(3, 8'h52, 1'b1, 1'b0);
      load(0, 8'h60, 1'b1, 1'b0);
      wait_grant(1'b1, "st_wait");
      check("st_grant", 32'(GRANT), 32'(4'b1000));
      lane_en[3] = 1'b0;
      aborts = 0;
      for (int k = 0; k < int'(STALL_LIMIT); k++) begin
         cycle();
         if (ABORT) aborts++;
      end
      check("st_abort_early", 32'(aborts), 32'(0));
      cycle();
      check("st_abort", 32'(ABORT), 32'(1));
      check("st_grant_drop", 32'(GRANT), 32'(0));
      check("st_buf_valid", 32'(TxValidWord), 32'(1));
      check("st_buf_data", 32'(TxData), 32'(8'h51));
      sb.push_back(8'h60);
      nw = 1'b1;
      cycle();
      check("st_next_grant", 32'(GRANT), 32'(4'b0001));
      check("st_abort_pulse", 32'(ABORT), 32'(0));
      wait_grant(1'b0, "st_release");
      cycle();
      check("st_delivered", 32'(sb.size()), 32'(0));
      lane_len[3] = lane_pos[3];
      lane_en[3]  = 1'b1;

      // Reset mid-message with a valid buffer and the owner still requesting.
      nw = 1'b0;
      load(1, 8'h81, 1'b0, 1'b0);
      load(1, 8'h82, 1'b0, 1'b0);
      load(1, 8'h83, 1'b1, 1'b0);
      wait_grant(1'b1, "mr_wait");
      check("mr_grant", 32'(GRANT), 32'(4'b0010));
      cycle();
      check("mr_valid", 32'(TxValidWord), 32'(1));
      nw         = 1'b1;
      TxNextWord = 1'b1;
      CLEAR      = 1'b1;
      #1;
      check("mr_grant_clr", 32'(GRANT), 32'(0));
      check("mr_empty_clr", 32'(TxIsEmpty), 32'(1));
      check("mr_ack_clr", 32'(REQ_ACK), 32'(0));
      reset_model();
      cycle();
      CLEAR = 1'b0;
      load(0, 8'h90, 1'b1, 1'b1);
      load(2, 8'hA0, 1'b1, 1'b1);
      wait_grant(1'b1, "mr_wait0");
      check("mr_first_grant", 32'(GRANT), 32'(4'b0001));
      wait_grant(1'b0, "mr_rel0");
      wait_grant(1'b1, "mr_wait2");
      check("mr_second_grant", 32'(GRANT), 32'(4'b0100));
      wait_grant(1'b0, "mr_rel2");
      cycle();
      cycle();
      check("final_delivered", 32'(sb.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
